jtdsp16_prog_seq: RTL and testbench
===================================

# jtdsp16_prog_seq

Program sequencer for the JTDSP16 core: owns the program counter and the PT/PR/PI pointer registers, and drives the ROM address. It consumes the control pulses produced by the instruction decoder (goto/call/return, halt, do-loop start, X-register loads) and closes the fetch loop by presenting the next instruction address. It also runs the single-level hardware do-loop and takes external interrupts.

## Interface
Parameters:
- IRQ_VEC, 16'h0001, interrupt vector address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cen  in  1  clock enable; all state changes only on clk edges with cen=1.
- goto_ja  in  1  jump to {pc[15:12], i_field}.
- call_ja  in  1  as goto_ja, plus pr <= pc.
- goto_b  in  1  B-class branch; subcode i_field[10:8].
- i_field  in  12  jump target / B subcode.
- pc_halt  in  1  hold pc this cycle (second word of double-word instruction).
- do_start  in  1  start do-loop.
- do_data  in  11  [10:7] NI, the body length; [6:0] K, the repeat count.
- xaau_imm_load, xaau_ram_load  in  1  load load_data into the X register selected by r_field.
- r_field  in  3  1=pt, 2=pr, 3=pi; other codes are ignored.
- load_data  in  16  register load value.
- irq  in  1  external interrupt request, level.
- rom_addr  out  16  current pc.
- pt, pr, pi  out  16  pointer registers.
- do_active  out  1  loop in progress.
- in_irq  out  1  inside interrupt service.
- irq_ack  out  1  one-cen pulse when the vector is taken.

## Operation
- Reset: pc, pt, pr, pi, loop registers = 0; do_active, in_irq, irq_ack, irq_pend = 0.
- pc on a branch cycle always means the address after the word being decoded. Subroutine links store this value unchanged.
- goto_b subcodes:
  - 000 return: pc <= pr.
  - 001 ireturn: pc <= pi, in_irq <= 0.
  - 010 goto pt: pc <= pt.
  - 011 call pt: pr <= pc, pc <= pt.
  - 1xx: no-op, and pc increments.
- Priority of pc update on each cen cycle:
  1. Branch (goto_ja/call_ja/goto_b). A branch also clears do_active.
  2. IRQ take.
  3. Loop wrap.
  4. pc_halt hold.
  5. pc+1, wrapping 16'hFFFF to 0.
- X loads: the write happens on the load cycle. If call_ja or call pt writes pr in the same cycle, the call wins over a pr load. Same rule for IRQ take against a pi load.
- IRQ:
  - A rising edge of irq sets irq_pend.
  - The interrupt is taken when irq_pend is set and in_irq, do_active, pc_halt, any branch and do_start are all 0.
  - On take: pi <= pc, pc <= IRQ_VEC, in_irq <= 1, irq_pend <= 0, irq_ack = 1 for one cen.
- Do-loop:
  - On do_start with NI≠0 and K≠0: lstart <= pc, lend <= pc+NI−1, kleft <= K, do_active <= 1. pc still advances normally this cycle.
  - Wrap: if do_active, pc == lend and pc_halt = 0, then:
    - kleft > 1: pc <= lstart, kleft−1.
    - kleft == 1: pc+1, do_active <= 0.
  - NI=0 or K=0: do_start is a no-op.
  - do_start while already active restarts the loop; there is no nesting.
  - pc_halt at lend defers the wrap until the cycle the pc would advance.

## Timing
- All outputs are registered; rom_addr changes one clk edge (with cen) after the control pulse.
- Branch latency: 1 cen cycle, from goto_ja high to rom_addr = target.
- irq edge to irq_ack: at least 2 cen cycles (edge detect register, then take).
- irq_ack goes high on the same edge that pc becomes IRQ_VEC.
- cen=0 freezes all state, including the irq edge detector.
- Reset mid-loop or mid-IRQ aborts immediately; all outputs return to their reset values.

## Structure
- Shared package/header jtdsp16_defs: goto_b subcode constants, r_field codes for pt/pr/pi, and the default IRQ vector. The decoder uses the same constants.
- One sub-module, jtdsp16_do_loop:
  - holds lstart, lend and kleft;
  - outputs do_active and wrap (with lstart);
  - its inputs are pc, pc_halt, do_start, do_data and a branch-abort signal.
- The top level holds the pc mux, the pointer registers and the IRQ logic.

## Test plan
- After reset, with cen=1 and no control pulses, rom_addr counts 0, 1, 2, 3. Hold pc_halt high for 1 cycle at pc=3: rom_addr stays at 3 for one extra cycle.
- call_ja with i_field=12'h123 at pc=16'h4010 → pr=16'h4010, rom_addr=16'h4123. Then goto_b subcode 000 → rom_addr=16'h4010.
- do_start at pc=16'h0020 with NI=3, K=2 → rom_addr sequence 20,21,22,20,21,22,23. do_active drops on the transition to 23. Also check K=0: no loop.
- goto_ja at pc=16'h0021 inside an active loop → jump taken, do_active=0, no wrap afterwards.
- irq rises while do_active=1 → not taken until the loop ends. On take: pi = return address, rom_addr=IRQ_VEC, irq_ack pulses once. ireturn → rom_addr=pi, in_irq=0.
- xaau_imm_load to r_field=2 (pr) in the same cycle as a call_pt with pt=16'h0100 → pr = call link, not load_data; rom_addr=16'h0100.

Source files
------------

// File: rtl/jtdsp16_defs.sv
// Constants shared by the JTDSP16 decoder and program sequencer.
// Covers goto_b subcodes, X-register select codes and the default interrupt vector.
package jtdsp16_defs;

    localparam logic [2:0] B_RETURN  = 3'b000;
    localparam logic [2:0] B_IRETURN = 3'b001;
    localparam logic [2:0] B_GOTO_PT = 3'b010;
    localparam logic [2:0] B_CALL_PT = 3'b011;

    localparam logic [2:0] R_PT = 3'd1;
    localparam logic [2:0] R_PR = 3'd2;
    localparam logic [2:0] R_PI = 3'd3;

    localparam logic [15:0] IRQ_VEC_DEFAULT = 16'h0001;

endpackage

// File: rtl/jtdsp16_do_loop.sv
// Single-level hardware do-loop: tracks the loop window and repeat count,
// and asks the pc mux to jump back to lstart at the end of each pass but the last.
module jtdsp16_do_loop (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [15:0] pc,
    input  logic        pc_halt,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic        abort,
    output logic        do_active,
    output logic        wrap,
    output logic [15:0] lstart
);
    logic [15:0] lstart_q, lend_q;
    logic [6:0]  kleft_q;
    logic        active_q;
    logic [3:0]  ni;
    logic [6:0]  k;
    logic        start_ok;
    logic        at_end;

    assign ni       = do_data[10:7];
    assign k        = do_data[6:0];
    assign start_ok = do_start && (ni != 4'd0) && (k != 7'd0);
    // A halted pc at lend is not "at the end" yet: the wrap waits for the advance.
    assign at_end   = active_q && (pc == lend_q) && !pc_halt;
    assign wrap     = at_end && (kleft_q > 7'd1) && !start_ok && !abort;

    assign do_active = active_q;
    assign lstart    = lstart_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lstart_q <= 16'd0;
            lend_q   <= 16'd0;
            kleft_q  <= 7'd0;
            active_q <= 1'b0;
        end else if (cen) begin
            if (abort) begin
                active_q <= 1'b0;
            end else if (start_ok) begin
                lstart_q <= pc;
                lend_q   <= pc + {12'd0, ni} - 16'd1;
                kleft_q  <= k;
                active_q <= 1'b1;
            end else if (at_end) begin
                if (kleft_q > 7'd1) begin
                    kleft_q <= kleft_q - 7'd1;
                end else begin
                    active_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/jtdsp16_prog_seq.sv
// JTDSP16 program sequencer: pc mux, PT/PR/PI pointers and interrupt entry.
// rom_addr is the registered pc; every control pulse takes effect on the next cen edge.
module jtdsp16_prog_seq
    import jtdsp16_defs::*;
#(
    parameter logic [15:0] IRQ_VEC = IRQ_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        goto_ja,
    input  logic        call_ja,
    input  logic        goto_b,
    input  logic [11:0] i_field,
    input  logic        pc_halt,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic        xaau_imm_load,
    input  logic        xaau_ram_load,
    input  logic [2:0]  r_field,
    input  logic [15:0] load_data,
    input  logic        irq,
    output logic [15:0] rom_addr,
    output logic [15:0] pt,
    output logic [15:0] pr,
    output logic [15:0] pi,
    output logic        do_active,
    output logic        in_irq,
    output logic        irq_ack
);
    logic [15:0] pc_q, pc_d, pt_q, pt_d, pr_q, pr_d, pi_q, pi_d;
    logic        irq_q, irq_pend_q, in_irq_q, in_irq_d, irq_ack_q;
    logic [2:0]  sub;
    logic        b_ret, b_iret, b_gpt, b_cpt, branch, take, x_load;
    logic        loop_active, loop_wrap;
    logic [15:0] loop_start;

    assign sub    = i_field[10:8];
    assign b_ret  = goto_b && (sub == B_RETURN);
    assign b_iret = goto_b && (sub == B_IRETURN);
    assign b_gpt  = goto_b && (sub == B_GOTO_PT);
    assign b_cpt  = goto_b && (sub == B_CALL_PT);
    // goto_b subcodes 1xx are no-ops for the pc, so they do not abort a loop.
    assign branch = goto_ja || call_ja || b_ret || b_iret || b_gpt || b_cpt;
    assign take   = irq_pend_q && !in_irq_q && !loop_active && !pc_halt
                    && !branch && !goto_b && !do_start;
    assign x_load = xaau_imm_load || xaau_ram_load;

    jtdsp16_do_loop u_do_loop (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .pc       (pc_q),
        .pc_halt  (pc_halt),
        .do_start (do_start),
        .do_data  (do_data),
        .abort    (branch),
        .do_active(loop_active),
        .wrap     (loop_wrap),
        .lstart   (loop_start)
    );

    always_comb begin
        pc_d = pc_q + 16'd1;
        if (goto_ja || call_ja) pc_d = {pc_q[15:12], i_field};
        else if (b_ret)         pc_d = pr_q;
        else if (b_iret)        pc_d = pi_q;
        else if (b_gpt || b_cpt) pc_d = pt_q;
        else if (take)          pc_d = IRQ_VEC;
        else if (loop_wrap)     pc_d = loop_start;
        else if (pc_halt)       pc_d = pc_q;
    end

    // Link writes from calls and interrupt entry override a same-cycle register load.
    always_comb begin
        pt_d = (x_load && r_field == R_PT) ? load_data : pt_q;
        pr_d = (x_load && r_field == R_PR) ? load_data : pr_q;
        pi_d = (x_load && r_field == R_PI) ? load_data : pi_q;
        if (call_ja || b_cpt) pr_d = pc_q;
        if (take)             pi_d = pc_q;
        in_irq_d = in_irq_q;
        if (b_iret)           in_irq_d = 1'b0;
        if (take)             in_irq_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= 16'd0;
            pt_q       <= 16'd0;
            pr_q       <= 16'd0;
            pi_q       <= 16'd0;
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            in_irq_q   <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else if (cen) begin
            pc_q      <= pc_d;
            pt_q      <= pt_d;
            pr_q      <= pr_d;
            pi_q      <= pi_d;
            irq_q     <= irq;
            in_irq_q  <= in_irq_d;
            irq_ack_q <= take;
            if (irq && !irq_q) irq_pend_q <= 1'b1;
            else if (take)     irq_pend_q <= 1'b0;
        end
    end

    assign rom_addr  = pc_q;
    assign pt        = pt_q;
    assign pr        = pr_q;
    assign pi        = pi_q;
    assign do_active = loop_active;
    assign in_irq    = in_irq_q;
    assign irq_ack   = irq_ack_q;
endmodule

// File: tb/tb_jtdsp16_prog_seq.sv
// Directed table-driven bench for jtdsp16_prog_seq, plus hand-written reset and cen/irq sequences.
module tb_jtdsp16_prog_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        goto_ja = 1'b0, call_ja = 1'b0, goto_b = 1'b0;
    logic [11:0] i_field = 12'd0;
    logic        pc_halt = 1'b0, do_start = 1'b0;
    logic [10:0] do_data = 11'd0;
    logic        xaau_imm_load = 1'b0, xaau_ram_load = 1'b0;
    logic [2:0]  r_field = 3'd0;
    logic [15:0] load_data = 16'd0;
    logic        irq = 1'b0;
    logic [15:0] rom_addr, pt, pr, pi;
    logic        do_active, in_irq, irq_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtdsp16_prog_seq #(.IRQ_VEC(16'h0001)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .goto_ja(goto_ja), .call_ja(call_ja), .goto_b(goto_b), .i_field(i_field),
        .pc_halt(pc_halt), .do_start(do_start), .do_data(do_data),
        .xaau_imm_load(xaau_imm_load), .xaau_ram_load(xaau_ram_load),
        .r_field(r_field), .load_data(load_data), .irq(irq),
        .rom_addr(rom_addr), .pt(pt), .pr(pr), .pi(pi),
        .do_active(do_active), .in_irq(in_irq), .irq_ack(irq_ack)
    );

    typedef struct {
        logic        cen, goto_ja, call_ja, goto_b;
        logic [11:0] i_field;
        logic        pc_halt, do_start;
        logic [10:0] do_data;
        logic        imm, ram;
        logic [2:0]  r_field;
        logic [15:0] load_data;
        logic        irq;
        logic [15:0] e_rom, e_pt, e_pr, e_pi;
        logic        e_act, e_inirq, e_ack;
    } vec_t;

    vec_t vecs[$];
    vec_t r;
    logic irq_lvl;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Start a new row: inputs idle, expected outputs carried over except the ack pulse.
    task automatic nr();
        r.cen = 1'b1; r.goto_ja = 1'b0; r.call_ja = 1'b0; r.goto_b = 1'b0;
        r.i_field = 12'd0; r.pc_halt = 1'b0; r.do_start = 1'b0; r.do_data = 11'd0;
        r.imm = 1'b0; r.ram = 1'b0; r.r_field = 3'd0; r.load_data = 16'd0;
        r.irq = irq_lvl; r.e_ack = 1'b0;
    endtask

    task automatic pu(input logic [15:0] rom);
        r.e_rom = rom;
        vecs.push_back(r);
    endtask

    task automatic drive(input vec_t v);
        cen = v.cen; goto_ja = v.goto_ja; call_ja = v.call_ja; goto_b = v.goto_b;
        i_field = v.i_field; pc_halt = v.pc_halt; do_start = v.do_start; do_data = v.do_data;
        xaau_imm_load = v.imm; xaau_ram_load = v.ram; r_field = v.r_field;
        load_data = v.load_data; irq = v.irq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        irq_lvl = 1'b0;
        r.e_pt = 16'd0; r.e_pr = 16'd0; r.e_pi = 16'd0;
        r.e_act = 1'b0; r.e_inirq = 1'b0;

        // Free run, then pc_halt at pc=3
        nr(); pu(16'h0001);
        nr(); pu(16'h0002);
        nr(); pu(16'h0003);
        nr(); r.pc_halt = 1; pu(16'h0003);
        nr(); pu(16'h0004);
        // Reach 0x4010 via pt, call_ja / return, B no-op
        nr(); r.imm = 1; r.r_field = 3'd1; r.load_data = 16'h4010; r.e_pt = 16'h4010; pu(16'h0005);
        nr(); r.goto_b = 1; r.i_field = 12'h200; pu(16'h4010);
        nr(); r.call_ja = 1; r.i_field = 12'h123; r.e_pr = 16'h4010; pu(16'h4123);
        nr(); r.goto_b = 1; r.i_field = 12'h000; pu(16'h4010);
        nr(); r.goto_b = 1; r.i_field = 12'h400; pu(16'h4011);
        // Loop NI=3 K=2 at 0x20
        nr(); r.ram = 1; r.r_field = 3'd1; r.load_data = 16'h0020; r.e_pt = 16'h0020; pu(16'h4012);
        nr(); r.goto_b = 1; r.i_field = 12'h200; pu(16'h0020);
        nr(); r.do_start = 1; r.do_data = {4'd3, 7'd2}; r.e_act = 1; pu(16'h0021);
        nr(); pu(16'h0022);
        nr(); pu(16'h0020);
        nr(); pu(16'h0021);
        nr(); pu(16'h0022);
        nr(); r.e_act = 0; pu(16'h0023);
        // K=0 is a no-op
        nr(); r.do_start = 1; r.do_data = {4'd3, 7'd0}; pu(16'h0024);
        nr(); pu(16'h0025);
        nr(); pu(16'h0026);
        // Branch inside a loop aborts it
        nr(); r.goto_ja = 1; r.i_field = 12'h020; pu(16'h0020);
        nr(); r.do_start = 1; r.do_data = {4'd3, 7'd2}; r.e_act = 1; pu(16'h0021);
        nr(); r.goto_ja = 1; r.i_field = 12'h021; r.e_act = 0; pu(16'h0021);
        nr(); pu(16'h0022);
        nr(); pu(16'h0023);
        // IRQ during loop is deferred until the loop ends
        nr(); r.goto_ja = 1; r.i_field = 12'h020; pu(16'h0020);
        nr(); r.do_start = 1; r.do_data = {4'd3, 7'd2}; r.e_act = 1; pu(16'h0021);
        irq_lvl = 1'b1;
        nr(); pu(16'h0022);
        nr(); pu(16'h0020);
        nr(); pu(16'h0021);
        nr(); pu(16'h0022);
        nr(); r.e_act = 0; pu(16'h0023);
        nr(); r.e_pi = 16'h0023; r.e_inirq = 1; r.e_ack = 1; pu(16'h0001);
        nr(); pu(16'h0002);
        nr(); r.goto_b = 1; r.i_field = 12'h100; r.e_inirq = 0; pu(16'h0023);
        nr(); pu(16'h0024);
        irq_lvl = 1'b0;
        nr(); pu(16'h0025);
        // call pt wins over a same-cycle pr load
        nr(); r.imm = 1; r.r_field = 3'd1; r.load_data = 16'h0100; r.e_pt = 16'h0100; pu(16'h0026);
        nr(); r.goto_b = 1; r.i_field = 12'h300; r.imm = 1; r.r_field = 3'd2;
              r.load_data = 16'hBEEF; r.e_pr = 16'h0026; pu(16'h0100);
        nr(); pu(16'h0101);
        // IRQ take wins over a same-cycle pi load
        irq_lvl = 1'b1;
        nr(); pu(16'h0102);
        nr(); r.imm = 1; r.r_field = 3'd3; r.load_data = 16'h5555;
              r.e_pi = 16'h0102; r.e_inirq = 1; r.e_ack = 1; pu(16'h0001);
        nr(); r.imm = 1; r.r_field = 3'd3; r.load_data = 16'h7777; r.e_pi = 16'h7777; pu(16'h0002);
        nr(); r.goto_b = 1; r.i_field = 12'h100; r.e_inirq = 0; pu(16'h7777);
        irq_lvl = 1'b0;
        nr(); pu(16'h7778);
        // cen=0 freezes, unused r_field ignored, pc wrap at 0xFFFF
        nr(); r.cen = 0; r.goto_ja = 1; r.i_field = 12'h000; pu(16'h7778);
        nr(); pu(16'h7779);
        nr(); r.imm = 1; r.r_field = 3'd4; r.load_data = 16'h1234; pu(16'h777A);
        nr(); r.imm = 1; r.r_field = 3'd1; r.load_data = 16'hFFFF; r.e_pt = 16'hFFFF; pu(16'h777B);
        nr(); r.goto_b = 1; r.i_field = 12'h200; pu(16'hFFFF);
        nr(); pu(16'h0000);
        // pc_halt at lend defers the wrap
        nr(); r.do_start = 1; r.do_data = {4'd2, 7'd2}; r.e_act = 1; pu(16'h0001);
        nr(); r.pc_halt = 1; pu(16'h0001);
        nr(); pu(16'h0000);
        nr(); pu(16'h0001);
        nr(); r.e_act = 0; pu(16'h0002);

        // Reset state
        #12;
        chk("reset_rom", rom_addr, 16'h0000);
        chk("reset_ptrs", pt | pr | pi, 16'h0000);
        chk("reset_flags", {13'd0, do_active, in_irq, irq_ack}, 16'h0000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            $display("row %0d: rom=%h pt=%h pr=%h pi=%h act=%b irq=%b ack=%b",
                     i, rom_addr, pt, pr, pi, do_active, in_irq, irq_ack);
            chk($sformatf("row%0d_rom", i), rom_addr, vecs[i].e_rom);
            chk($sformatf("row%0d_pt", i), pt, vecs[i].e_pt);
            chk($sformatf("row%0d_pr", i), pr, vecs[i].e_pr);
            chk($sformatf("row%0d_pi", i), pi, vecs[i].e_pi);
            chk($sformatf("row%0d_act", i), {15'd0, do_active}, {15'd0, vecs[i].e_act});
            chk($sformatf("row%0d_inirq", i), {15'd0, in_irq}, {15'd0, vecs[i].e_inirq});
            chk($sformatf("row%0d_ack", i), {15'd0, irq_ack}, {15'd0, vecs[i].e_ack});
        end
        nr(); drive(r);

        // Asynchronous reset in the middle of a loop
        do_start = 1'b1; do_data = {4'd4, 7'd5};
        tick();
        do_start = 1'b0;
        $display("seq reset: rom=%h act=%b", rom_addr, do_active);
        chk("rstseq_rom_before", rom_addr, 16'h0003);
        chk("rstseq_act_before", {15'd0, do_active}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstseq_rom_async", rom_addr, 16'h0000);
        chk("rstseq_act_async", {15'd0, do_active}, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        $display("seq reset release: rom=%h act=%b", rom_addr, do_active);
        chk("rstseq_rom_after", rom_addr, 16'h0001);
        chk("rstseq_act_after", {15'd0, do_active}, 16'd0);

        // irq rising while cen=0 is only seen once cen returns
        cen = 1'b0; irq = 1'b1;
        tick(); tick(); tick();
        chk("censeq_rom_frozen", rom_addr, 16'h0001);
        chk("censeq_ack_frozen", {15'd0, irq_ack}, 16'd0);
        cen = 1'b1;
        tick();
        chk("censeq_rom_edge", rom_addr, 16'h0002);
        chk("censeq_ack_edge", {15'd0, irq_ack}, 16'd0);
        tick();
        $display("seq cen/irq take: rom=%h pi=%h ack=%b", rom_addr, pi, irq_ack);
        chk("censeq_rom_take", rom_addr, 16'h0001);
        chk("censeq_pi_take", pi, 16'h0002);
        chk("censeq_ack_take", {15'd0, irq_ack}, 16'd1);
        chk("censeq_inirq_take", {15'd0, in_irq}, 16'd1);
        irq = 1'b0;
        tick();
        chk("censeq_rom_next", rom_addr, 16'h0002);
        chk("censeq_ack_next", {15'd0, irq_ack}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
